l2_mesi_tag_ctrl: RTL
=====================

Name: l2_mesi_tag_ctrl

Overview:
Parametrised set-associative L2 tag/state controller. It serves L1 trace commands and snooped bus commands, maintaining MESI state and pseudo-LRU per set. It issues shared-bus operations with a valid/ack handshake, drives the snoop response, and keeps hit/miss statistics. It replaces the fixed-geometry L2 cache model under the cache test bench; ways, sets, line size and address width are all generalised.

Parameters:
ADDR_W, 32, address width in bits
WAYS, 8, associativity; power of two, 2..16
SETS, 16384, number of sets; power of two
LINE_BYTES, 64, line size in bytes; power of two
CNT_W, 32, statistics counter width

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
reqValid  in  1  command present
reqReady  out  1  controller accepts a command this cycle
reqCmd  in  4  0 L1 read, 1 L1 write, 2 L1 instr read, 3 snoop invalidate, 4 snoop read, 5 snoop write, 6 snoop RWIM, 8 clear
reqAddr  in  ADDR_W  command address
respValid  out  1  one-cycle pulse at command completion
respHit  out  1  L1 command hit; 0 for snoop and clear
busValid  out  1  bus operation pending
busOp  out  2  0 READ, 1 WRITE (writeback), 2 INVALIDATE, 3 RWIM
busAddr  out  ADDR_W  line-aligned bus address
busAck  in  1  bus completed the operation
snoopIn  in  2  other caches' result, sampled with busAck: 0 HIT, 1 HITM, 2/3 NOHIT
snoopOut  out  2  our result for snooped commands, valid with respValid
readCnt, writeCnt, hitCnt, missCnt  out  CNT_W each  statistics

Behaviour:
- Fields: OFF_W=$clog2(LINE_BYTES), IDX_W=$clog2(SETS), TAG_W=ADDR_W-IDX_W-OFF_W.
- Reset, asynchronous: all ways I; all PLRU bits 0; all counters 0; FSM in IDLE; reqReady=1; respValid=0; busValid=0; busOp=0; busAddr=0; snoopOut=2.
- Reset asserted mid-operation aborts the command with no response.
- FSM states: IDLE, LOOKUP, WB, FILL, UPG, UPDATE, RESP, CLEAR.
- IDLE: reqReady=1. Accept on reqValid&reqReady and latch cmd/addr. Go to CLEAR for cmd 8, else LOOKUP. Unknown cmd: RESP with no state change.
- LOOKUP (1 cycle): compare tags of non-I ways and select a hit way. Victim is the lowest-index I way; if none, the PLRU victim.
- L1 read/instr read, hit: no bus op. Miss: go to WB if victim is M, else FILL.
- WB: busOp=WRITE, busAddr=victim tag|index.
- FILL: busOp=READ; new state is E if snoopIn is NOHIT, else S.
- L1 write, hit: M stays M; E becomes M with no bus op; S goes to UPG (INVALIDATE), then M.
- L1 write, miss: WB if needed, then RWIM, state M.
- Snoop read: M goes to S with HITM and a WB issued; E goes to S with HIT; S gives HIT; miss gives NOHIT.
- Snoop RWIM: M goes to I with HITM and WB; E/S go to I with HIT.
- Snoop invalidate: S goes to I with HIT.
- Snoop write: no change, NOHIT.
- Bus handshake: busValid, busOp and busAddr are held stable until the cycle busAck=1. busValid drops the next cycle. busAck while busValid=0 is ignored.
- UPDATE: write tag/state. PLRU update (tree of WAYS-1 bits, pointing away from the touched way) on L1 hits and fills only; never on snoops.
- RESP: respValid=1 for 1 cycle, then IDLE.
- Counters: L1 read/instr read increments readCnt; L1 write increments writeCnt; each L1 command increments exactly one of hitCnt/missCnt. All counters saturate at all-ones.
- Latency, zero-wait bus: hit takes 3 cycles from accept to respValid; each bus op adds 1 + wait cycles.
- CLEAR: invalidates one set per cycle via an index counter, SETS cycles; resets PLRU and counters; no bus ops; RESP when the index wraps to 0.

Decomposition:
- Package l2_pkg: cmd, busOp, snoop and MESI enums; state typedef; helper functions for field width.
- Sub-module l2_plru (WAYS): combinational victim select plus next-bits for a touched way; instantiated once and shared by the active set.

Test Plan:
- Parameters WAYS=4, SETS=16, LINE_BYTES=64. Read 0x0000_1000, snoopIn=NOHIT -> READ 0x1000, miss, E, missCnt=1; re-read -> respHit=1, no bus op, hitCnt=1.
- Write 0x1000 (E) -> no bus op, M. Snoop read 0x1000 -> WRITE 0x1000, snoopOut=HITM, state S.
- Read with snoopIn=HIT at 0x2000 -> S. Write 0x2000 -> INVALIDATE 0x2000, then M.
- Fill 5 tags into set 0 (0x0000, 0x0400, ...) -> 5th evicts the PLRU way. If that way is M, WRITE precedes READ.
- Hold busAck low 10 cycles -> busValid/busOp/busAddr stable throughout, reqReady=0; then clear (cmd 8) -> respValid after 16 cycles, counters 0, all subsequent reads miss.

Source files
------------

// File: rtl/l2_mesi_tag_ctrl_pkg.sv
// Shared types for the L2 tag/state controller: commands, bus ops, snoop results, MESI and FSM states.
// Address field widths are derived here so every file agrees on the geometry.
package l2_pkg;

  typedef enum logic [3:0] {
    CMD_RD    = 4'd0,
    CMD_WR    = 4'd1,
    CMD_IRD   = 4'd2,
    CMD_SINV  = 4'd3,
    CMD_SRD   = 4'd4,
    CMD_SWR   = 4'd5,
    CMD_SRWIM = 4'd6,
    CMD_CLEAR = 4'd8
  } cmd_e;

  typedef enum logic [1:0] {
    BUS_READ  = 2'd0,
    BUS_WRITE = 2'd1,
    BUS_INV   = 2'd2,
    BUS_RWIM  = 2'd3
  } busOp_e;

  typedef enum logic [1:0] {
    SNP_HIT   = 2'd0,
    SNP_HITM  = 2'd1,
    SNP_NOHIT = 2'd2
  } snoop_e;

  typedef enum logic [1:0] {
    MESI_I = 2'd0,
    MESI_S = 2'd1,
    MESI_E = 2'd2,
    MESI_M = 2'd3
  } mesi_e;

  typedef enum logic [2:0] {
    ST_IDLE, ST_LOOKUP, ST_WB, ST_FILL, ST_UPG, ST_UPDATE, ST_RESP, ST_CLEAR
  } state_e;

  function automatic int offW(input int lineBytes);
    return $clog2(lineBytes);
  endfunction

  function automatic int idxW(input int sets);
    return $clog2(sets);
  endfunction

  function automatic int tagW(input int addrW, input int sets, input int lineBytes);
    return addrW - $clog2(sets) - $clog2(lineBytes);
  endfunction

  function automatic logic isL1(input logic [3:0] c);
    return (c == CMD_RD) || (c == CMD_WR) || (c == CMD_IRD);
  endfunction

  function automatic logic isSnoop(input logic [3:0] c);
    return (c >= CMD_SINV) && (c <= CMD_SRWIM);
  endfunction

endpackage

// File: rtl/l2_mesi_tag_ctrl_plru.sv
// Tree pseudo-LRU for one set: victim walk and next bits after touching a way; combinational.
// No handshake; the caller presents the active set's bits and the way it touched.
module l2_plru #(
  parameter int WAYS = 8
) (
  input  logic [WAYS-2:0]         plruBits,
  input  logic [$clog2(WAYS)-1:0] touchWay,
  output logic [$clog2(WAYS)-1:0] victimWay,
  output logic [WAYS-2:0]         plruNext
);
  localparam int LVL = $clog2(WAYS);

  // Heap-numbered nodes 1..WAYS-1 live at bit node-1; a 1 steers toward the right child.
  always_comb begin
    int nv;
    int nu;
    nv = 1;
    for (int l = 0; l < LVL; l++) begin
      nv = 2 * nv + int'(plruBits[nv-1]);
    end
    victimWay = LVL'(nv - WAYS);

    plruNext = plruBits;
    nu = 1;
    for (int l = 0; l < LVL; l++) begin
      plruNext[nu-1] = ~touchWay[LVL-1-l];
      nu = 2 * nu + int'(touchWay[LVL-1-l]);
    end
  end

endmodule

// File: rtl/l2_mesi_tag_ctrl.sv
// Set-associative L2 tag/MESI controller; hit = 3 cycles accept-to-response, +1+wait per bus op.
// One command in flight: reqReady only in IDLE; bus ops held until busAck.
module l2_mesi_tag_ctrl
  import l2_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int WAYS       = 8,
  parameter int SETS       = 16384,
  parameter int LINE_BYTES = 64,
  parameter int CNT_W      = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              reqValid,
  output logic              reqReady,
  input  logic [3:0]        reqCmd,
  input  logic [ADDR_W-1:0] reqAddr,
  output logic              respValid,
  output logic              respHit,
  output logic              busValid,
  output logic [1:0]        busOp,
  output logic [ADDR_W-1:0] busAddr,
  input  logic              busAck,
  input  logic [1:0]        snoopIn,
  output logic [1:0]        snoopOut,
  output logic [CNT_W-1:0]  readCnt,
  output logic [CNT_W-1:0]  writeCnt,
  output logic [CNT_W-1:0]  hitCnt,
  output logic [CNT_W-1:0]  missCnt
);
  localparam int OFF_W = offW(LINE_BYTES);
  localparam int IDX_W = idxW(SETS);
  localparam int TAG_W = tagW(ADDR_W, SETS, LINE_BYTES);
  localparam int WAY_W = $clog2(WAYS);

  state_e state, stateNext;

  logic [3:0]        cmdR;
  logic [ADDR_W-1:0] addrR;
  logic [WAY_W-1:0]  wayR;
  logic              hitR;
  mesi_e             newStR;
  logic              wrR;
  logic [1:0]        snoopR;
  logic [IDX_W-1:0]  clrIdx;

  mesi_e            stMem   [SETS][WAYS];
  logic [TAG_W-1:0] tagMem  [SETS][WAYS];
  logic [WAYS-2:0]  plruMem [SETS];

  logic [TAG_W-1:0]  reqTag;
  logic [IDX_W-1:0]  reqIdx;
  logic [ADDR_W-1:0] lineAddr, victimAddr;

  logic             hit, freeFound;
  logic [WAY_W-1:0] hitWay, freeWay, plruVictim, selWay;
  mesi_e            selSt;
  logic [TAG_W-1:0] selTag;
  logic [WAYS-2:0]  plruNext;

  logic              busLoad;
  busOp_e            busOpNext;
  logic [ADDR_W-1:0] busAddrNext;
  logic              setNew, wrNext;
  mesi_e             newStNext;
  snoop_e            snoopNext;

  assign reqTag     = addrR[ADDR_W-1 -: TAG_W];
  assign reqIdx     = addrR[OFF_W +: IDX_W];
  assign lineAddr   = {reqTag, reqIdx, {OFF_W{1'b0}}};
  assign victimAddr = {selTag, reqIdx, {OFF_W{1'b0}}};

  always_comb begin
    hit       = 1'b0;
    hitWay    = '0;
    freeFound = 1'b0;
    freeWay   = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (!hit && stMem[reqIdx][w] != MESI_I && tagMem[reqIdx][w] == reqTag) begin
        hit    = 1'b1;
        hitWay = WAY_W'(w);
      end
      if (!freeFound && stMem[reqIdx][w] == MESI_I) begin
        freeFound = 1'b1;
        freeWay   = WAY_W'(w);
      end
    end
  end

  // On a miss the selected way is the victim: an empty way first, otherwise the PLRU choice.
  assign selWay = hit ? hitWay : (freeFound ? freeWay : plruVictim);
  assign selSt  = stMem[reqIdx][selWay];
  assign selTag = tagMem[reqIdx][selWay];

  l2_plru #(.WAYS(WAYS)) uPlru (
    .plruBits (plruMem[reqIdx]),
    .touchWay (wayR),
    .victimWay(plruVictim),
    .plruNext (plruNext)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= stateNext;
  end

  always_comb begin
    stateNext   = state;
    busLoad     = 1'b0;
    busOpNext   = BUS_READ;
    busAddrNext = lineAddr;
    setNew      = 1'b0;
    wrNext      = 1'b0;
    newStNext   = MESI_I;
    snoopNext   = SNP_NOHIT;
    unique case (state)
      ST_IDLE: begin
        if (reqValid) begin
          if (reqCmd == CMD_CLEAR)  stateNext = ST_CLEAR;
          else if (reqCmd <= 4'd6)  stateNext = ST_LOOKUP;
          else                      stateNext = ST_RESP;
        end
      end
      ST_LOOKUP: begin
        setNew    = 1'b1;
        stateNext = ST_UPDATE;
        case (cmdR)
          CMD_RD, CMD_IRD, CMD_WR: begin
            if (hit && !(cmdR == CMD_WR && selSt == MESI_S)) begin
              wrNext    = 1'b1;
              newStNext = (cmdR == CMD_WR) ? MESI_M : selSt;
            end else if (hit) begin
              busLoad   = 1'b1;
              busOpNext = BUS_INV;
              stateNext = ST_UPG;
            end else if (selSt == MESI_M) begin
              busLoad     = 1'b1;
              busOpNext   = BUS_WRITE;
              busAddrNext = victimAddr;
              stateNext   = ST_WB;
            end else begin
              busLoad   = 1'b1;
              busOpNext = (cmdR == CMD_WR) ? BUS_RWIM : BUS_READ;
              stateNext = ST_FILL;
            end
          end
          CMD_SRD, CMD_SRWIM: begin
            if (hit) begin
              wrNext    = 1'b1;
              newStNext = (cmdR == CMD_SRD) ? MESI_S : MESI_I;
              snoopNext = (selSt == MESI_M) ? SNP_HITM : SNP_HIT;
              if (selSt == MESI_M) begin
                busLoad   = 1'b1;
                busOpNext = BUS_WRITE;
                stateNext = ST_WB;
              end
            end
          end
          CMD_SINV: begin
            if (hit && selSt == MESI_S) begin
              wrNext    = 1'b1;
              snoopNext = SNP_HIT;
            end
          end
          default: ;
        endcase
      end
      ST_WB: begin
        if (busValid && busAck) begin
          if (isL1(cmdR)) begin
            busLoad   = 1'b1;
            busOpNext = (cmdR == CMD_WR) ? BUS_RWIM : BUS_READ;
            stateNext = ST_FILL;
          end else begin
            stateNext = ST_UPDATE;
          end
        end
      end
      ST_FILL: begin
        if (busValid && busAck) begin
          setNew    = 1'b1;
          wrNext    = 1'b1;
          newStNext = (cmdR == CMD_WR) ? MESI_M : (snoopIn[1] ? MESI_E : MESI_S);
          stateNext = ST_UPDATE;
        end
      end
      ST_UPG: begin
        if (busValid && busAck) begin
          setNew    = 1'b1;
          wrNext    = 1'b1;
          newStNext = MESI_M;
          stateNext = ST_UPDATE;
        end
      end
      ST_UPDATE: stateNext = ST_RESP;
      ST_RESP:   stateNext = ST_IDLE;
      ST_CLEAR:  if (clrIdx == IDX_W'(SETS - 1)) stateNext = ST_RESP;
    endcase
  end

  assign reqReady  = (state == ST_IDLE);
  assign respValid = (state == ST_RESP);
  assign respHit   = (state == ST_RESP) && isL1(cmdR) && hitR;
  assign snoopOut  = ((state == ST_RESP) && isSnoop(cmdR)) ? snoopR : SNP_NOHIT;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmdR     <= '0;
      addrR    <= '0;
      wayR     <= '0;
      hitR     <= 1'b0;
      newStR   <= MESI_I;
      wrR      <= 1'b0;
      snoopR   <= SNP_NOHIT;
      busValid <= 1'b0;
      busOp    <= BUS_READ;
      busAddr  <= '0;
      clrIdx   <= '0;
      readCnt  <= '0;
      writeCnt <= '0;
      hitCnt   <= '0;
      missCnt  <= '0;
    end else begin
      if (reqValid && reqReady) begin
        cmdR  <= reqCmd;
        addrR <= reqAddr;
      end
      if (state == ST_LOOKUP) begin
        wayR   <= selWay;
        hitR   <= hit;
        snoopR <= snoopNext;
      end
      if (setNew) begin
        newStR <= newStNext;
        wrR    <= wrNext;
      end
      if (busLoad) begin
        busValid <= 1'b1;
        busOp    <= busOpNext;
        busAddr  <= busAddrNext;
      end else if (busValid && busAck) begin
        busValid <= 1'b0;
      end
      // Statistics saturate at all-ones rather than wrapping.
      if (state == ST_CLEAR) begin
        clrIdx   <= clrIdx + 1'b1;
        readCnt  <= '0;
        writeCnt <= '0;
        hitCnt   <= '0;
        missCnt  <= '0;
      end else if (state == ST_LOOKUP && isL1(cmdR)) begin
        if (cmdR == CMD_WR) begin
          if (~&writeCnt) writeCnt <= writeCnt + CNT_W'(1);
        end else begin
          if (~&readCnt) readCnt <= readCnt + CNT_W'(1);
        end
        if (hit) begin
          if (~&hitCnt) hitCnt <= hitCnt + CNT_W'(1);
        end else begin
          if (~&missCnt) missCnt <= missCnt + CNT_W'(1);
        end
      end
    end
  end

  // PLRU moves on L1 traffic only, so snoops never disturb replacement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < SETS; s++) begin
        plruMem[s] <= '0;
        for (int w = 0; w < WAYS; w++) stMem[s][w] <= MESI_I;
      end
    end else if (state == ST_CLEAR) begin
      plruMem[clrIdx] <= '0;
      for (int w = 0; w < WAYS; w++) stMem[clrIdx][w] <= MESI_I;
    end else if (state == ST_UPDATE) begin
      if (wrR) stMem[reqIdx][wayR] <= newStR;
      if (isL1(cmdR)) plruMem[reqIdx] <= plruNext;
    end
  end

  always_ff @(posedge clk) begin
    if (state == ST_UPDATE && wrR) tagMem[reqIdx][wayR] <= reqTag;
  end

endmodule
